// File: rtl/uart_tx_fifo_if.sv
//============================================================================
// Module      : uart_tx_fifo_if
// Description : Byte-write / status bundle for the UART transmitter with FIFO.
//               master : producer side (drives din/wr_en/ovf_clr, sees status)
//               slave  : the transmitter itself
//   din      [7:0] byte to transmit
//   wr_en          single-cycle write strobe for din
//   ovf_clr        clears the sticky overflow flag
//   tx             serial line, idle high
//   tx_busy        FIFO non-empty or frame in progress
//   full           FIFO holds FIFO_DEPTH bytes
//   overflow       sticky: a write was dropped
// Revision    : 1.0 - initial release
//============================================================================
`timescale 1ns/1ps
`default_nettype none

interface uart_tx_fifo_if;
    logic [7:0] din;
    logic       wr_en;
    logic       ovf_clr;
    logic       tx;
    logic       tx_busy;
    logic       full;
    logic       overflow;

    modport master (
        output din, wr_en, ovf_clr,
        input  tx, tx_busy, full, overflow
    );

    modport slave (
        input  din, wr_en, ovf_clr,
        output tx, tx_busy, full, overflow
    );
endinterface

`default_nettype wire

// File: rtl/uart_tx_fifo.sv
//============================================================================
// Module      : uart_tx_fifo
// Description : 8-bit UART transmitter fed by a power-of-two byte FIFO.
//               Frame is 8N1 by default; defining UART_TX_PARITY_EN inserts
//               an even-parity bit between the data bits and the stop bit.
//   clk_50m  in   system clock, rising edge
//   rst_n    in   synchronous active-low reset
//   bus      slave modport of uart_tx_fifo_if (din, wr_en, ovf_clr in;
//                 tx, tx_busy, full, overflow out)
// Parameters  : CLKS_PER_BIT (2..65535), FIFO_DEPTH (power of two, 2..256)
// Revision    : 1.0 - initial release
//============================================================================
`timescale 1ns/1ps
`default_nettype none

module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 16
) (
    input  wire logic      clk_50m,
    input  wire logic      rst_n,
    uart_tx_fifo_if.slave  bus
);

    localparam int                  c_ADDR_W   = $clog2(FIFO_DEPTH);
    localparam logic [c_ADDR_W:0]   c_DEPTH    = (c_ADDR_W + 1)'(FIFO_DEPTH);
    localparam logic [c_ADDR_W:0]   c_CNT_ONE  = 1;
    localparam logic [c_ADDR_W-1:0] c_PTR_ONE  = 1;
    localparam logic [15:0]         c_BIT_MAX  = 16'(CLKS_PER_BIT - 1);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_START  = 3'd1;
    localparam logic [2:0] c_ST_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] c_ST_PARITY = 3'd3;
`endif
    localparam logic [2:0] c_ST_STOP   = 3'd4;

    // FIFO storage and bookkeeping
    logic [7:0]          r_mem [FIFO_DEPTH];
    logic [c_ADDR_W-1:0] r_wr_ptr;
    logic [c_ADDR_W-1:0] r_rd_ptr;
    logic [c_ADDR_W:0]   r_count;
    logic [c_ADDR_W:0]   w_count_next;
    logic                r_full;
    logic                r_overflow;
    logic                w_push;
    logic                w_pop;
    logic                w_empty;

    // Transmitter
    logic [2:0]  r_state;
    logic [2:0]  w_state_next;
    logic [15:0] r_bit_cnt;
    logic [15:0] w_bit_cnt_next;
    logic [2:0]  r_bit_idx;
    logic [2:0]  w_bit_idx_next;
    logic [7:0]  r_data;
    logic        r_tx;
    logic        w_tx_next;
    logic        w_bit_end;

    assign w_empty   = (r_count == '0);
    // A write while full is dropped even if a pop frees a slot on the same edge.
    assign w_push    = bus.wr_en & ~r_full;
    assign w_bit_end = (r_bit_cnt == c_BIT_MAX);

    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + c_CNT_ONE;
            2'b01:   w_count_next = r_count - c_CNT_ONE;
            default: w_count_next = r_count;
        endcase
    end

    always_ff @(posedge clk_50m) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_full     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            r_count <= w_count_next;
            r_full  <= (w_count_next == c_DEPTH);
            // A drop wins over a simultaneous clear so no drop goes unreported.
            if (bus.wr_en && r_full)
                r_overflow <= 1'b1;
            else if (bus.ovf_clr)
                r_overflow <= 1'b0;
        end
    end

    // Storage is not reset; occupancy alone defines which entries are valid.
    always_ff @(posedge clk_50m) begin
        if (rst_n && w_push)
            r_mem[r_wr_ptr] <= bus.din;
    end

    always_comb begin
        w_state_next   = r_state;
        w_bit_cnt_next = '0;
        w_bit_idx_next = r_bit_idx;
        w_pop          = 1'b0;

        if (r_state != c_ST_IDLE)
            w_bit_cnt_next = w_bit_end ? 16'd0 : r_bit_cnt + 16'd1;

        case (r_state)
            c_ST_IDLE: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_state_next = c_ST_START;
                end
            end
            c_ST_START: begin
                if (w_bit_end) begin
                    w_state_next   = c_ST_DATA;
                    w_bit_idx_next = 3'd0;
                end
            end
            c_ST_DATA: begin
                if (w_bit_end) begin
                    w_bit_idx_next = r_bit_idx + 3'd1;
                    if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        w_state_next = c_ST_PARITY;
`else
                        w_state_next = c_ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            c_ST_PARITY: begin
                if (w_bit_end)
                    w_state_next = c_ST_STOP;
            end
`endif
            c_ST_STOP: begin
                if (w_bit_end) begin
                    // Back-to-back frames: go straight to START with no idle bit.
                    if (!w_empty) begin
                        w_pop        = 1'b1;
                        w_state_next = c_ST_START;
                    end else begin
                        w_state_next = c_ST_IDLE;
                    end
                end
            end
            default: w_state_next = c_ST_IDLE;
        endcase
    end

    // The line level is registered from the current state, so tx trails the
    // state register by one clock; every bit still lasts CLKS_PER_BIT clocks.
    always_comb begin
        w_tx_next = 1'b1;
        case (r_state)
            c_ST_START:  w_tx_next = 1'b0;
            c_ST_DATA:   w_tx_next = r_data[r_bit_idx];
`ifdef UART_TX_PARITY_EN
            c_ST_PARITY: w_tx_next = ^r_data;
`endif
            default:     w_tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk_50m) begin
        if (!rst_n) begin
            r_state   <= c_ST_IDLE;
            r_bit_cnt <= '0;
            r_bit_idx <= '0;
            r_data    <= '0;
            r_tx      <= 1'b1;
        end else begin
            r_state   <= w_state_next;
            r_bit_cnt <= w_bit_cnt_next;
            r_bit_idx <= w_bit_idx_next;
            r_tx      <= w_tx_next;
            if (w_pop)
                r_data <= r_mem[r_rd_ptr];
        end
    end

    assign bus.tx       = r_tx;
    assign bus.tx_busy  = (r_state != c_ST_IDLE) || !w_empty;
    assign bus.full     = r_full;
    assign bus.overflow = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
//============================================================================
// Module      : tb_uart_tx_fifo
// Description : Self-checking bench for uart_tx_fifo. Written bytes are
//               queued as expected frames; a serial monitor decodes tx and
//               compares each received frame against the queue.
// Revision    : 1.0 - initial release
//============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_uart_tx_fifo;

    localparam int CPB   = 4;
    localparam int DEPTH = 16;
`ifdef UART_TX_PARITY_EN
    localparam int NB    = 11;
`else
    localparam int NB    = 10;
`endif
    localparam int FL    = NB * CPB;

    logic clk_50m = 1'b0;
    logic rst_n   = 1'b0;

    uart_tx_fifo_if bus ();

    uart_tx_fifo #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) u_dut (
        .clk_50m (clk_50m),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    always #5 clk_50m = ~clk_50m;

    int cyc = 0;
    always @(posedge clk_50m) cyc <= cyc + 1;

    int         n_checks = 0;
    int         n_pass   = 0;
    int         n_sent   = 0;
    logic [7:0] exp_q [$];
    int         starts [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    endtask

    task automatic tick();
        @(posedge clk_50m);
        #1;
    endtask

    task automatic write_byte(input logic [7:0] b, input bit sent);
        bus.din   = b;
        bus.wr_en = 1'b1;
        tick();
        bus.wr_en = 1'b0;
        if (sent) begin
            exp_q.push_back(b);
            n_sent++;
        end
    endtask

    task automatic wait_idle(input int bound, output int at_cyc);
        int n;
        n = 0;
        while (bus.tx_busy && n < bound) begin
            tick();
            n++;
        end
        if (bus.tx_busy) begin
            n_checks++;
            $display("FAIL wait_idle: tx_busy still 1 after %0d clocks, required 0", bound);
        end
        at_cyc = cyc;
    endtask

    // Serial monitor: samples every clock of a frame, requires each bit to be
    // stable for CPB clocks, then scores the frame against the queue.
    bit          m_active = 1'b0;
    int          m_k;
    int          m_start;
    bit          m_glitch;
    logic [10:0] m_bits;
    logic [7:0]  m_exp;

    always @(negedge clk_50m) begin
        if (!rst_n) begin
            m_active = 1'b0;
        end else if (!m_active && bus.tx == 1'b0) begin
            m_active = 1'b1;
            m_k      = 0;
            m_glitch = 1'b0;
            m_bits   = '0;
            m_start  = cyc;
        end
        if (m_active && rst_n) begin
            if ((m_k % CPB) == 0)
                m_bits[m_k / CPB] = bus.tx;
            else if (bus.tx !== m_bits[m_k / CPB])
                m_glitch = 1'b1;
            if (m_k == FL - 1) begin
                m_active = 1'b0;
                starts.push_back(m_start);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_frame: got byte 0x%0h, required no frame", m_bits[8:1]);
                end else begin
                    m_exp = exp_q.pop_front();
                    check("frame_data", 32'(m_bits[8:1]), 32'(m_exp));
                    check("frame_format", 32'({m_bits[0], m_bits[NB-1], m_glitch}), 32'(3'b010));
`ifdef UART_TX_PARITY_EN
                    check("frame_parity", 32'(m_bits[9]), 32'(^m_exp));
`endif
                end
            end else begin
                m_k++;
            end
        end
    end

    initial begin
        int w;
        int t;
        int s0;

        bus.din     = 8'h00;
        bus.wr_en   = 1'b0;
        bus.ovf_clr = 1'b0;

        // Reset with a write strobe held high: the write must not land.
        rst_n     = 1'b0;
        bus.din   = 8'h99;
        bus.wr_en = 1'b1;
        repeat (3) tick();
        check("rst_tx", 32'(bus.tx), 32'd1);
        check("rst_busy", 32'(bus.tx_busy), 32'd0);
        check("rst_full", 32'(bus.full), 32'd0);
        check("rst_overflow", 32'(bus.overflow), 32'd0);
        bus.wr_en = 1'b0;
        rst_n     = 1'b1;
        repeat (3) tick();
        check("post_rst_busy", 32'(bus.tx_busy), 32'd0);

        // Single byte 0xA5: tx falls two edges after the write.
        write_byte(8'hA5, 1'b1);
        w = cyc;
        check("a5_busy", 32'(bus.tx_busy), 32'd1);
        tick();
        check("a5_lat_n1_tx", 32'(bus.tx), 32'd1);
        tick();
        check("a5_lat_n2_tx", 32'(bus.tx), 32'd0);
        wait_idle(500, t);
        check("a5_busy_drop", 32'(t - w), 32'(1 + FL));
        repeat (2) tick();

        // Back-to-back 0x00, 0xFF: no idle gap between frames.
        s0 = starts.size();
        write_byte(8'h00, 1'b1);
        w = cyc;
        write_byte(8'hFF, 1'b1);
        wait_idle(1000, t);
        repeat (2) tick();
        check("b2b_total", 32'(t - w), 32'(1 + 2 * FL));
        check("b2b_frames", 32'(starts.size() - s0), 32'd2);
        if (starts.size() >= s0 + 2)
            check("b2b_gap", 32'(starts[s0+1] - starts[s0]), 32'(FL));

        // Fill past capacity: first byte pops at once, 17 fit, the 18th drops.
        for (int i = 0; i < 17; i++) begin
            write_byte(i[7:0], 1'b1);
            if (i == 16) begin
                check("fill_full", 32'(bus.full), 32'd1);
                check("fill_no_ovf", 32'(bus.overflow), 32'd0);
            end
        end
        write_byte(8'h11, 1'b0);
        check("drop_ovf", 32'(bus.overflow), 32'd1);
        bus.din     = 8'h55;
        bus.wr_en   = 1'b1;
        bus.ovf_clr = 1'b1;
        tick();
        bus.wr_en   = 1'b0;
        check("drop_and_clr_ovf", 32'(bus.overflow), 32'd1);
        tick();
        bus.ovf_clr = 1'b0;
        check("clr_ovf", 32'(bus.overflow), 32'd0);
        check("still_full", 32'(bus.full), 32'd1);
        wait_idle(17 * FL + 200, t);
        repeat (2) tick();
        check("drain_full", 32'(bus.full), 32'd0);

`ifdef UART_TX_PARITY_EN
        write_byte(8'h07, 1'b1);
        wait_idle(500, t);
        repeat (2) tick();
        write_byte(8'h03, 1'b1);
        wait_idle(500, t);
        repeat (2) tick();
`endif

        // Reset during the third data bit of 0x3C with two bytes queued.
        write_byte(8'h3C, 1'b0);
        w = cyc;
        write_byte(8'h81, 1'b0);
        write_byte(8'h42, 1'b0);
        while (cyc < w + 15) tick();
        rst_n = 1'b0;
        tick();
        check("mr_tx", 32'(bus.tx), 32'd1);
        check("mr_busy", 32'(bus.tx_busy), 32'd0);
        check("mr_full", 32'(bus.full), 32'd0);
        tick();
        rst_n = 1'b1;
        s0 = starts.size();
        repeat (200) tick();
        check("mr_busy_after", 32'(bus.tx_busy), 32'd0);
        check("mr_no_frames", 32'(starts.size() - s0), 32'd0);

        check("sb_empty", 32'(exp_q.size()), 32'd0);
        check("frame_count", 32'(starts.size()), 32'(n_sent));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
